// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM controller.
//   state_t          - controller FSM states
//   *_CYCLES_DEF     - default OE#/WE# low times, in clocks
//   *_W_DEF          - default SRAM geometry (1M x 8)
//   HB_W             - width of the optional heartbeat counter
package sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_TURN
    } state_t;

    localparam int RD_CYCLES_DEF = 2;
    localparam int WR_CYCLES_DEF = 2;
    localparam int ADDR_W_DEF    = 20;
    localparam int DATA_W_DEF    = 8;
    localparam int HB_W          = 26;

endpackage

// File: rtl/sram_async_ctrl_if.sv
// Single-beat request/response bus between on-chip logic and the SRAM
// controller.
//   req/we/addr/wdata : request from the master, held until ready
//   ready             : controller idle, request accepted when req & ready
//   rdata/rvalid      : read data and its one-cycle update pulse
//   wdone             : one-cycle pulse when a write has finished
interface sram_async_ctrl_if
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              wdone;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata, rvalid, wdone
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata, rvalid, wdone
    );
endinterface

// File: rtl/sram_heartbeat.sv
// Board-alive indicator: free-running counter whose MSB drives an LED.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   o_led        : counter MSB
module sram_heartbeat
    import sram_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    output logic o_led
);
    logic [HB_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= r_cnt + HB_W'(1);
    end

    assign o_led = r_cnt[HB_W-1];
endmodule

// File: rtl/sram_async_ctrl.sv
// Asynchronous SRAM controller: turns single-beat requests on the bus
// interface into timed CE#/OE#/WE# sequences with programmable wait states.
// Every pin-side and bus-side output comes straight from a register.
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   bus (slave)        : request/response handshake
//   o_sram_addr        : SRAM address pins
//   o_sram_dq          : data toward the pad, enabled by o_sram_dq_oe
//   i_sram_dq          : data sampled from the pad
//   o_sram_ce_n/oe_n/we_n : active-low strobes
//   o_led              : heartbeat, only when SRAM_CTRL_HEARTBEAT_EN is defined
module sram_async_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int WR_CYCLES = WR_CYCLES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sram_async_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
`ifdef SRAM_CTRL_HEARTBEAT_EN
    ,
    output logic              o_led
`endif
);
    if (RD_CYCLES < 1) begin : g_bad_rd
        $error("RD_CYCLES must be at least 1");
    end
    if (WR_CYCLES < 1) begin : g_bad_wr
        $error("WR_CYCLES must be at least 1");
    end

    localparam int CNT_MAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    state_t            r_state,   w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
    logic              r_ready,   w_ready_nxt;
    logic              r_rvalid,  w_rvalid_nxt;
    logic              r_wdone,   w_wdone_nxt;
    logic [DATA_W-1:0] r_rdata,   w_rdata_nxt;
    logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
    logic [DATA_W-1:0] r_dq,      w_dq_nxt;
    logic              r_dq_oe,   w_dq_oe_nxt;
    logic              r_ce_n,    w_ce_n_nxt;
    logic              r_oe_n,    w_oe_n_nxt;
    logic              r_we_n,    w_we_n_nxt;
    logic              r_last_rd, w_last_rd_nxt;
    logic              w_accept;

    // r_ready is only ever high in IDLE, so it alone qualifies acceptance
    assign w_accept = bus.req & r_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_rvalid  <= 1'b0;
            r_wdone   <= 1'b0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_dq      <= '0;
            r_dq_oe   <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_last_rd <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ready   <= w_ready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_wdone   <= w_wdone_nxt;
            r_rdata   <= w_rdata_nxt;
            r_addr    <= w_addr_nxt;
            r_dq      <= w_dq_nxt;
            r_dq_oe   <= w_dq_oe_nxt;
            r_ce_n    <= w_ce_n_nxt;
            r_oe_n    <= w_oe_n_nxt;
            r_we_n    <= w_we_n_nxt;
            r_last_rd <= w_last_rd_nxt;
        end
    end

    // Next-state logic computes the value every output register takes on
    // the coming edge, so strobes change exactly on state boundaries.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ready_nxt   = r_ready;
        w_rvalid_nxt  = 1'b0;
        w_wdone_nxt   = 1'b0;
        w_rdata_nxt   = r_rdata;
        w_addr_nxt    = r_addr;
        w_dq_nxt      = r_dq;
        w_dq_oe_nxt   = r_dq_oe;
        w_ce_n_nxt    = r_ce_n;
        w_oe_n_nxt    = r_oe_n;
        w_we_n_nxt    = r_we_n;
        w_last_rd_nxt = r_last_rd;

        case (r_state)
            ST_IDLE: begin
                w_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_ready_nxt   = 1'b0;
                    w_addr_nxt    = bus.addr;
                    w_last_rd_nxt = ~bus.we;
                    w_cnt_nxt     = '0;
                    if (!bus.we) begin
                        w_state_nxt = ST_READ;
                        w_ce_n_nxt  = 1'b0;
                        w_oe_n_nxt  = 1'b0;
                    end else begin
                        w_dq_nxt = bus.wdata;
                        // SRAM may still be driving DQ after OE# rises
                        if (r_last_rd) begin
                            w_state_nxt = ST_TURN;
                        end else begin
                            w_state_nxt = ST_WR_SETUP;
                            w_ce_n_nxt  = 1'b0;
                            w_dq_oe_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_READ: begin
                if (r_cnt == RD_LAST) begin
                    w_rdata_nxt  = i_sram_dq;
                    w_rvalid_nxt = 1'b1;
                    w_ce_n_nxt   = 1'b1;
                    w_oe_n_nxt   = 1'b1;
                    w_ready_nxt  = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_TURN: begin
                w_state_nxt = ST_WR_SETUP;
                w_ce_n_nxt  = 1'b0;
                w_dq_oe_nxt = 1'b1;
            end
            ST_WR_SETUP: begin
                w_state_nxt = ST_WR_PULSE;
                w_we_n_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
            ST_WR_PULSE: begin
                if (r_cnt == WR_LAST) begin
                    w_we_n_nxt  = 1'b1;
                    w_state_nxt = ST_WR_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                w_dq_oe_nxt = 1'b0;
                w_ce_n_nxt  = 1'b1;
                w_wdone_nxt = 1'b1;
                w_ready_nxt = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.ready    = r_ready;
    assign bus.rdata    = r_rdata;
    assign bus.rvalid   = r_rvalid;
    assign bus.wdone    = r_wdone;
    assign o_sram_addr  = r_addr;
    assign o_sram_dq    = r_dq;
    assign o_sram_dq_oe = r_dq_oe;
    assign o_sram_ce_n  = r_ce_n;
    assign o_sram_oe_n  = r_oe_n;
    assign o_sram_we_n  = r_we_n;

`ifdef SRAM_CTRL_HEARTBEAT_EN
    sram_heartbeat u_heartbeat (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .o_led (o_led)
    );
`endif
endmodule

// File: tb/tb_sram_async_ctrl.sv
// Self-checking bench for sram_async_ctrl. Two instances: A with the default
// timing (RD=2, WR=2) and B with RD=1, WR=5. Each has a behavioural SRAM model
// on its pins and a scoreboard of expected completions (kind, data, latency).
module tb_sram_async_ctrl;
    localparam int AW = 20;
    localparam int DW = 8;
    localparam int RD_A = 2, WR_A = 2;
    localparam int RD_B = 1, WR_B = 5;

    typedef struct {
        logic          is_wr;
        logic [DW-1:0] data;
        int            acc;
        int            lat;
    } sb_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   viol_a = 0, viol_b = 0;
    int   wlow_a = 0, wlow_b = 0;
    logic last_rd_a = 1'b0, last_rd_b = 1'b0;

    sb_t           sb_a[$], sb_b[$];
    logic [DW-1:0] ref_a[int], ref_b[int];
    logic [DW-1:0] mem_a[int], mem_b[int];

    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] dq_a, dq_b;
    logic [DW-1:0] sdi_a = 8'hEE, sdi_b = 8'hEE;
    logic          dq_oe_a, dq_oe_b, ce_n_a, ce_n_b, oe_n_a, oe_n_b, we_n_a, we_n_b;
`ifdef SRAM_CTRL_HEARTBEAT_EN
    logic          led_a, led_b;
`endif

    sram_async_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    sram_async_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    sram_async_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RD_A), .WR_CYCLES(WR_A)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .bus(bus_a),
        .o_sram_addr(addr_a), .o_sram_dq(dq_a), .o_sram_dq_oe(dq_oe_a), .i_sram_dq(sdi_a),
        .o_sram_ce_n(ce_n_a), .o_sram_oe_n(oe_n_a), .o_sram_we_n(we_n_a)
`ifdef SRAM_CTRL_HEARTBEAT_EN
        , .o_led(led_a)
`endif
    );

    sram_async_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RD_B), .WR_CYCLES(WR_B)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .bus(bus_b),
        .o_sram_addr(addr_b), .o_sram_dq(dq_b), .o_sram_dq_oe(dq_oe_b), .i_sram_dq(sdi_b),
        .o_sram_ce_n(ce_n_b), .o_sram_oe_n(oe_n_b), .o_sram_we_n(we_n_b)
`ifdef SRAM_CTRL_HEARTBEAT_EN
        , .o_led(led_b)
`endif
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Unwritten SRAM locations read back as A5 in the models.
    function automatic logic [DW-1:0] mrd(input logic [DW-1:0] m[int], input int a);
        return m.exists(a) ? m[a] : 8'hA5;
    endfunction

    // SRAM models, pin monitors and scoreboard checkers, all at the falling edge.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!ce_n_a && !we_n_a && dq_oe_a) mem_a[int'(addr_a)] = dq_a;
            sdi_a = (!ce_n_a && !oe_n_a) ? mrd(mem_a, int'(addr_a)) : 8'hEE;
            if (!ce_n_b && !we_n_b && dq_oe_b) mem_b[int'(addr_b)] = dq_b;
            sdi_b = (!ce_n_b && !oe_n_b) ? mrd(mem_b, int'(addr_b)) : 8'hEE;

            if (!oe_n_a && dq_oe_a) viol_a++;
            if (!oe_n_b && dq_oe_b) viol_b++;

            if (rst_a) wlow_a = 0;
            else if (!we_n_a) wlow_a++;
            else if (wlow_a != 0) begin chk("a_we_low_len", wlow_a, WR_A); wlow_a = 0; end
            if (rst_b) wlow_b = 0;
            else if (!we_n_b) wlow_b++;
            else if (wlow_b != 0) begin chk("b_we_low_len", wlow_b, WR_B); wlow_b = 0; end

            if (bus_a.rvalid || bus_a.wdone) begin
                if (sb_a.size() == 0) chk("a_spurious_done", 1, 0);
                else begin
                    e = sb_a.pop_front();
                    chk("a_done_kind", bus_a.wdone, e.is_wr);
                    chk("a_done_both", bus_a.rvalid & bus_a.wdone, 0);
                    if (!e.is_wr) chk("a_rdata", bus_a.rdata, e.data);
                    chk("a_latency", cyc - e.acc, e.lat);
                end
            end
            if (bus_b.rvalid || bus_b.wdone) begin
                if (sb_b.size() == 0) chk("b_spurious_done", 1, 0);
                else begin
                    e = sb_b.pop_front();
                    chk("b_done_kind", bus_b.wdone, e.is_wr);
                    chk("b_done_both", bus_b.rvalid & bus_b.wdone, 0);
                    if (!e.is_wr) chk("b_rdata", bus_b.rdata, e.data);
                    chk("b_latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // Drive one request on instance b (0=A, 1=B), hold it until accepted,
    // and push the expected completion.
    task automatic issue(input bit b, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        sb_t e;
        int  n;
        logic rdy;
        @(negedge clk);
        if (!b) begin bus_a.req = 1'b1; bus_a.we = w; bus_a.addr = ad; bus_a.wdata = d; end
        else    begin bus_b.req = 1'b1; bus_b.we = w; bus_b.addr = ad; bus_b.wdata = d; end
        n = 0;
        rdy = b ? bus_b.ready : bus_a.ready;
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
            rdy = b ? bus_b.ready : bus_a.ready;
        end
        chk(b ? "b_accept_wait" : "a_accept_wait", n < 200, 1);
        e.is_wr = w;
        e.acc   = cyc + 1;
        if (!b) begin
            if (w) begin e.data = d; e.lat = WR_A + 2 + (last_rd_a ? 1 : 0); ref_a[int'(ad)] = d; end
            else   begin e.data = mrd(ref_a, int'(ad)); e.lat = RD_A; end
            last_rd_a = !w;
            sb_a.push_back(e);
        end else begin
            if (w) begin e.data = d; e.lat = WR_B + 2 + (last_rd_b ? 1 : 0); ref_b[int'(ad)] = d; end
            else   begin e.data = mrd(ref_b, int'(ad)); e.lat = RD_B; end
            last_rd_b = !w;
            sb_b.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!b) bus_a.req = 1'b0; else bus_b.req = 1'b0;
    endtask

    task automatic drain(input bit b);
        int n = 0;
        while ((b ? sb_b.size() : sb_a.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(b ? "b_drain" : "a_drain", n < 200, 1);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_a_ready", bus_a.ready, 0);
        chk("rst_a_ce_n", ce_n_a, 1);
        chk("rst_a_oe_n", oe_n_a, 1);
        chk("rst_a_we_n", we_n_a, 1);
        chk("rst_a_dq_oe", dq_oe_a, 0);
        chk("rst_a_addr", addr_a, 0);
        chk("rst_a_rdata", bus_a.rdata, 0);
        chk("rst_a_pulses", {bus_a.rvalid, bus_a.wdone}, 0);
        chk("rst_b_ready", bus_b.ready, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("rel_a_ready_before_edge", bus_a.ready, 0);
        @(posedge clk); #1;
        chk("rel_a_ready_after_edge", bus_a.ready, 1);
        chk("rel_b_ready_after_edge", bus_b.ready, 1);

        // Write then read back
        issue(0, 1, 20'h12345, 8'h5A);
        issue(0, 0, 20'h12345, 8'h00);
        drain(0);

        // Read followed immediately by a write: one turnaround cycle
        issue(0, 0, 20'h00001, 8'h00);
        issue(0, 1, 20'h00002, 8'hC3);
        drain(0);
        chk("a_mem_00002", mrd(mem_a, 32'h2), 8'hC3);

        // Back-to-back writes across the address wrap, no turnaround
        issue(0, 1, 20'hFFFFF, 8'h11);
        issue(0, 1, 20'h00000, 8'h22);
        drain(0);
        chk("a_mem_fffff", mrd(mem_a, 32'hFFFFF), 8'h11);
        chk("a_mem_00000", mrd(mem_a, 32'h0), 8'h22);
        issue(0, 0, 20'hFFFFF, 8'h00);
        issue(0, 0, 20'h00000, 8'h00);
        drain(0);

        // Instance B: RD=1, WR=5
        issue(1, 1, 20'h00ABC, 8'h77);
        issue(1, 0, 20'h00ABC, 8'h00);
        issue(1, 1, 20'h00ABD, 8'h55);
        drain(1);
        chk("b_mem_00abd", mrd(mem_b, 32'hABD), 8'h55);

        // Reset in the third WE# low cycle of a write on B
        issue(1, 1, 20'h00300, 8'h99);
        repeat (3) @(posedge clk);
        #2;
        chk("b_we_low_before_rst", we_n_b, 0);
        rst_b = 1'b1;
        #1;
        chk("b_rst_we_n", we_n_b, 1);
        chk("b_rst_ce_n", ce_n_b, 1);
        chk("b_rst_oe_n", oe_n_b, 1);
        chk("b_rst_dq_oe", dq_oe_b, 0);
        chk("b_rst_ready", bus_b.ready, 0);
        sb_b.delete();
        last_rd_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("b_rel_ready_before_edge", bus_b.ready, 0);
        @(posedge clk); #1;
        chk("b_rel_ready_after_edge", bus_b.ready, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("b_no_wdone_after_rst", bus_b.wdone, 0);
        end
        issue(1, 0, 20'h00ABC, 8'h00);
        drain(1);

        repeat (3) @(negedge clk);
        chk("a_contention", viol_a, 0);
        chk("b_contention", viol_b, 0);
        chk("a_sb_empty", sb_a.size(), 0);
        chk("b_sb_empty", sb_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end
endmodule
